bf_async_master: RTL and testbench

- Initiator side of the Blackfin EBIU asynchronous memory protocol: drives AMS/ARE/AWE/address, drives or samples the data bus, and honours ARDY wait states.
- A local command port issues single read or write transactions with programmable setup, access and hold phases.
- Used as the bus driver in on-FPGA self-test and in benches that read decimated channel data out of the FPGA's Blackfin memory window.

---
 rtl/bf_async_master.sv | 196 +++++++++++++++++++
 tb/tb_bf_async_master.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/bf_async_master.sv
// -----------------------------------------------------------------------------
// bf_async_master
//   Initiator for the Blackfin EBIU asynchronous memory protocol. A single
//   read or write taken from the local command port is run through the
//   SETUP / ACCESS / WAIT / HOLD phases. The block drives AMS, ARE, AWE, the
//   address and the data pad, and honours ARDY wait states.
//
// Optional feature (macro BF_ARDY_TIMEOUT_EN):
//   When defined, WAIT gives up after TIMEOUT_CYC clocks of ARDY low. The
//   transaction then leaves through HOLD and responds with rsp_err=1; read
//   data is not captured. When undefined, WAIT never times out and
//   o_rsp_err is tied to 0.
//
// Ports:
//   i_clk, i_rst          rising-edge clock, asynchronous active-low reset
//   i_cmd_valid/o_cmd_ready, i_cmd_wr, i_cmd_bank, i_cmd_addr, i_cmd_wdata
//                         command port (accepted only in IDLE)
//   o_rsp_valid, o_rsp_rdata, o_rsp_err
//                         completion pulse, read data (held), timeout flag
//   o_bus_addr, o_bus_ams, o_bus_are, o_bus_awe, o_bus_dout, o_bus_doe
//                         registered EBIU outputs (strobes are active-low)
//   i_bus_din, i_bus_ardy pad read data, asynchronous ready from responder
// -----------------------------------------------------------------------------
module bf_async_master #(
    parameter int SETUP_CYC   = 2,
    parameter int ACCESS_CYC  = 4,
    parameter int HOLD_CYC    = 1,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_cmd_valid,
    output logic        o_cmd_ready,
    input  logic        i_cmd_wr,
    input  logic [1:0]  i_cmd_bank,
    input  logic [18:0] i_cmd_addr,
    input  logic [15:0] i_cmd_wdata,
    output logic        o_rsp_valid,
    output logic [15:0] o_rsp_rdata,
    output logic        o_rsp_err,
    output logic [18:0] o_bus_addr,
    output logic [3:0]  o_bus_ams,
    output logic        o_bus_are,
    output logic        o_bus_awe,
    output logic [15:0] o_bus_dout,
    output logic        o_bus_doe,
    input  logic [15:0] i_bus_din,
    input  logic        i_bus_ardy
);

    typedef enum logic [2:0] {
        S_IDLE, S_SETUP, S_ACCESS, S_WAIT, S_HOLD
    } state_t;

    state_t      r_state;
    logic [3:0]  r_cnt;
    logic        r_wr;
    logic        r_cmd_ready;
    logic        r_rsp_valid;
    logic [15:0] r_rsp_rdata;
    logic [18:0] r_addr;
    logic [3:0]  r_ams;
    logic        r_are;
    logic        r_awe;
    logic [15:0] r_dout;
    logic        r_doe;
    logic        r_ardy_s1;
    logic        r_ardy_s2;

`ifdef BF_ARDY_TIMEOUT_EN
    localparam int WCW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    logic [WCW-1:0] r_wcnt;
    logic           r_err;
    assign o_rsp_err = r_err;
`else
    assign o_rsp_err = 1'b0;
`endif

    // ARDY comes from another timing domain; two flops before the FSM sees it.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_ardy_s1 <= 1'b0;
            r_ardy_s2 <= 1'b0;
        end else begin
            r_ardy_s1 <= i_bus_ardy;
            r_ardy_s2 <= r_ardy_s1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_wr        <= 1'b0;
            r_cmd_ready <= 1'b1;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_addr      <= '0;
            r_ams       <= 4'hF;
            r_are       <= 1'b1;
            r_awe       <= 1'b1;
            r_dout      <= '0;
            r_doe       <= 1'b0;
`ifdef BF_ARDY_TIMEOUT_EN
            r_wcnt      <= '0;
            r_err       <= 1'b0;
`endif
        end else begin
            r_rsp_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    // cmd_ready is high throughout IDLE, so valid alone accepts.
                    if (i_cmd_valid) begin
                        r_wr        <= i_cmd_wr;
                        r_addr      <= i_cmd_addr;
                        r_ams       <= ~(4'b0001 << i_cmd_bank);
                        r_doe       <= i_cmd_wr;
                        if (i_cmd_wr)
                            r_dout  <= i_cmd_wdata;
                        r_cnt       <= 4'(SETUP_CYC - 1);
                        r_cmd_ready <= 1'b0;
                        r_state     <= S_SETUP;
`ifdef BF_ARDY_TIMEOUT_EN
                        r_err       <= 1'b0;
`endif
                    end
                end
                S_SETUP: begin
                    if (r_cnt != 4'd0) begin
                        r_cnt <= r_cnt - 4'd1;
                    end else begin
                        if (r_wr) r_awe <= 1'b0;
                        else      r_are <= 1'b0;
                        r_cnt   <= 4'(ACCESS_CYC - 1);
                        r_state <= S_ACCESS;
                    end
                end
                S_ACCESS: begin
                    if (r_cnt != 4'd0) begin
                        r_cnt <= r_cnt - 4'd1;
                    end else begin
                        r_state <= S_WAIT;
`ifdef BF_ARDY_TIMEOUT_EN
                        r_wcnt  <= '0;
`endif
                    end
                end
                S_WAIT: begin
                    if (r_ardy_s2) begin
                        if (!r_wr)
                            r_rsp_rdata <= i_bus_din;
                        r_are   <= 1'b1;
                        r_awe   <= 1'b1;
                        r_cnt   <= 4'(HOLD_CYC);
                        r_state <= S_HOLD;
                    end
`ifdef BF_ARDY_TIMEOUT_EN
                    // This edge is the TIMEOUT_CYC-th WAIT clock with ARDY low.
                    else if (r_wcnt == WCW'(TIMEOUT_CYC - 1)) begin
                        r_are   <= 1'b1;
                        r_awe   <= 1'b1;
                        r_err   <= 1'b1;
                        r_cnt   <= 4'(HOLD_CYC);
                        r_state <= S_HOLD;
                    end else begin
                        r_wcnt  <= r_wcnt + 1'b1;
                    end
`endif
                end
                S_HOLD: begin
                    if (r_cnt != 4'd0) begin
                        r_cnt <= r_cnt - 4'd1;
                    end else begin
                        r_ams       <= 4'hF;
                        r_doe       <= 1'b0;
                        r_rsp_valid <= 1'b1;
                        r_cmd_ready <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_cmd_ready = r_cmd_ready;
    assign o_rsp_valid = r_rsp_valid;
    assign o_rsp_rdata = r_rsp_rdata;
    assign o_bus_addr  = r_addr;
    assign o_bus_ams   = r_ams;
    assign o_bus_are   = r_are;
    assign o_bus_awe   = r_awe;
    assign o_bus_dout  = r_dout;
    assign o_bus_doe   = r_doe;

endmodule

// File: tb/tb_bf_async_master.sv
// -----------------------------------------------------------------------------
// tb_bf_async_master
//   Directed bench for bf_async_master. Stimulus pushes the expected response
//   (read data, error flag, accept-to-rsp_valid latency) into a queue when a
//   command is accepted; a monitor pops and compares on every rsp_valid.
//   A bus watcher measures strobe widths and protocol invariants.
//   Latency is counted in rising edges from the accept edge to the edge that
//   raises rsp_valid (defaults: 2 setup + 4 access + 1 wait + 2 hold = 9).
// -----------------------------------------------------------------------------
module tb_bf_async_master;

`ifdef BF_ARDY_TIMEOUT_EN
    localparam int TO_CYC = 8;
`else
    localparam int TO_CYC = 255;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_wr = 1'b0;
    logic [1:0]  cmd_bank = '0;
    logic [18:0] cmd_addr = '0;
    logic [15:0] cmd_wdata = '0;
    logic        bus_ardy = 1'b1;
    logic        din_junk = 1'b0;
    logic [15:0] bus_din;
    logic        o_cmd_ready, o_rsp_valid, o_rsp_err;
    logic [15:0] o_rsp_rdata, o_bus_dout;
    logic [18:0] o_bus_addr;
    logic [3:0]  o_bus_ams;
    logic        o_bus_are, o_bus_awe, o_bus_doe;

    always #5 clk = ~clk;

    bf_async_master #(
        .SETUP_CYC(2), .ACCESS_CYC(4), .HOLD_CYC(1), .TIMEOUT_CYC(TO_CYC)
    ) dut (
        .i_clk(clk), .i_rst(rst_n),
        .i_cmd_valid(cmd_valid), .o_cmd_ready(o_cmd_ready),
        .i_cmd_wr(cmd_wr), .i_cmd_bank(cmd_bank), .i_cmd_addr(cmd_addr),
        .i_cmd_wdata(cmd_wdata),
        .o_rsp_valid(o_rsp_valid), .o_rsp_rdata(o_rsp_rdata), .o_rsp_err(o_rsp_err),
        .o_bus_addr(o_bus_addr), .o_bus_ams(o_bus_ams), .o_bus_are(o_bus_are),
        .o_bus_awe(o_bus_awe), .o_bus_dout(o_bus_dout), .o_bus_doe(o_bus_doe),
        .i_bus_din(bus_din), .i_bus_ardy(bus_ardy)
    );

    // Responder memory contents, hand-picked per address.
    function automatic logic [15:0] mem(input logic [18:0] a);
        case (a)
            19'h00010: mem = 16'hA5C3;
            19'h00020: mem = 16'h1357;
            19'h00021: mem = 16'h2468;
            19'h00030: mem = 16'hBEEF;
            default:   mem = 16'h0BAD;
        endcase
    endfunction

    always_comb bus_din = din_junk ? 16'hDEAD : mem(o_bus_addr);

    typedef struct {
        logic [15:0] rdata;
        logic        err;
        int          acc;
        int          lat;
    } exp_t;

    exp_t        sb_q[$];
    exp_t        mon_e;
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    logic [15:0] model_rdata = 16'h0000;
    logic [15:0] exp_dout = 16'h0000;

    // Bus watcher measurements
    int          are_run = 0, last_are = 0;
    int          awe_run = 0, last_awe = 0;
    int          doe_run = 0, last_doe = 0;
    int          f_run = 0,   last_f = 0;
    int          dout_bad = 0, are_low_cnt = 0, doe_cnt = 0;
    logic [3:0]  last_ams = 4'h0;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        if (rst_n && o_rsp_valid) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_rsp_valid actual=1 expected=0 (t=%0t)", $time);
            end else begin
                mon_e = sb_q.pop_front();
                chk("rsp_rdata", 32'(o_rsp_rdata), 32'(mon_e.rdata));
                chk("rsp_err", 32'(o_rsp_err), 32'(mon_e.err));
                chk("rsp_latency", 32'(cyc - mon_e.acc), 32'(mon_e.lat));
            end
        end
    end

    // Bus watcher
    always @(negedge clk) begin
        if (rst_n) begin
            if (!o_bus_are && !o_bus_awe) begin
                checks++; errors++;
                $display("FAIL are_awe_overlap actual=both_low expected=one_high (t=%0t)", $time);
            end
            if (o_bus_doe && !o_bus_are) begin
                checks++; errors++;
                $display("FAIL doe_during_read actual=1 expected=0 (t=%0t)", $time);
            end
            if (!o_bus_are) begin are_run++; are_low_cnt++; last_ams = o_bus_ams; end
            else if (are_run > 0) begin last_are = are_run; are_run = 0; end
            if (!o_bus_awe) begin awe_run++; last_ams = o_bus_ams; end
            else if (awe_run > 0) begin last_awe = awe_run; awe_run = 0; end
            if (o_bus_doe) begin
                doe_run++; doe_cnt++;
                if (o_bus_dout !== exp_dout) dout_bad++;
            end else if (doe_run > 0) begin last_doe = doe_run; doe_run = 0; end
            if (o_bus_ams == 4'hF) f_run++;
            else if (f_run > 0) begin last_f = f_run; f_run = 0; end
        end
    end

    // Issue one command and, on accept, push its expected response.
    task automatic send(input logic wr, input logic [1:0] bank, input logic [18:0] addr,
                        input logic [15:0] wd, input int lat, input logic err, input bit push);
        exp_t e;
        int   n;
        cmd_valid = 1'b1; cmd_wr = wr; cmd_bank = bank; cmd_addr = addr; cmd_wdata = wd;
        n = 0;
        do begin @(negedge clk); n++; end while (!o_cmd_ready && n < 100);
        if (!o_cmd_ready) begin
            checks++; errors++;
            $display("FAIL accept_timeout actual=not_ready expected=ready (t=%0t)", $time);
        end
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        if (push) begin
            if (!wr && !err) model_rdata = mem(addr);
            e.rdata = model_rdata; e.err = err; e.acc = cyc; e.lat = lat;
            sb_q.push_back(e);
        end
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 300 && sb_q.size() != 0; i++) @(negedge clk);
        chk(name, 32'(sb_q.size()), 32'd0);
        @(posedge clk); #1;
    endtask

    task automatic reset_meas();
        dout_bad = 0; are_low_cnt = 0; doe_cnt = 0;
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout actual=hung expected=finish");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset values
        repeat (3) @(negedge clk);
        chk("rst_cmd_ready", 32'(o_cmd_ready), 32'd1);
        chk("rst_rsp_valid", 32'(o_rsp_valid), 32'd0);
        chk("rst_rsp_rdata", 32'(o_rsp_rdata), 32'd0);
        chk("rst_rsp_err",   32'(o_rsp_err),   32'd0);
        chk("rst_bus_addr",  32'(o_bus_addr),  32'd0);
        chk("rst_bus_ams",   32'(o_bus_ams),   32'hF);
        chk("rst_bus_are",   32'(o_bus_are),   32'd1);
        chk("rst_bus_awe",   32'(o_bus_awe),   32'd1);
        chk("rst_bus_dout",  32'(o_bus_dout),  32'd0);
        chk("rst_bus_doe",   32'(o_bus_doe),   32'd0);
        rst_n = 1'b1;
        repeat (4) @(posedge clk); #1;

        // T1: read bank 0; ARE low 4 access + 1 wait = 5 clocks
        reset_meas();
        send(1'b0, 2'd0, 19'h00010, 16'h0, 9, 1'b0, 1'b1);
        drain("t1_drain");
        chk("t1_are_width", 32'(last_are), 32'd5);
        chk("t1_ams", 32'(last_ams), 32'hE);
        chk("t1_doe_cycles", 32'(doe_cnt), 32'd0);

        // T2: write bank 2; commands offered while busy must be ignored
        reset_meas();
        exp_dout = 16'h1234;
        send(1'b1, 2'd2, 19'h7FFFF, 16'h1234, 9, 1'b0, 1'b1);
        repeat (2) @(posedge clk); #1;
        cmd_valid = 1'b1; cmd_wr = 1'b0; cmd_addr = 19'h00001; cmd_bank = 2'd3;
        repeat (3) @(posedge clk); #1;
        cmd_valid = 1'b0;
        drain("t2_drain");
        chk("t2_awe_width", 32'(last_awe), 32'd5);
        chk("t2_ams", 32'(last_ams), 32'hB);
        chk("t2_doe_width", 32'(last_doe), 32'd9);
        chk("t2_dout_bad", 32'(dout_bad), 32'd0);
        chk("t2_are_low", 32'(are_low_cnt), 32'd0);
        chk("t2_addr_held", 32'(o_bus_addr), 32'h7FFFF);

        // T3: ARDY raised 20 clocks after ARE falls (edge 2 -> edge 22).
        // Synchroniser sees it at edge 24, WAIT exits at 25, rsp_valid at 27.
        reset_meas();
        bus_ardy = 1'b0; din_junk = 1'b1;
        repeat (3) @(posedge clk); #1;
        send(1'b0, 2'd1, 19'h00030, 16'h0, 27, 1'b0, 1'b1);
        repeat (22) @(posedge clk); #1;
        bus_ardy = 1'b1; din_junk = 1'b0;
        drain("t3_drain");
        chk("t3_are_width", 32'(last_are), 32'd23);

        // T4: back-to-back reads with cmd_valid held
        send(1'b0, 2'd3, 19'h00020, 16'h0, 9, 1'b0, 1'b1);
        send(1'b0, 2'd3, 19'h00021, 16'h0, 9, 1'b0, 1'b1);
        drain("t4_drain");
        chk("t4_ams_gap", 32'(last_f), 32'd1);

        // T5: reset during ACCESS of a write; no response expected
        exp_dout = 16'hCAFE;
        send(1'b1, 2'd1, 19'h00100, 16'hCAFE, 9, 1'b0, 1'b0);
        repeat (4) @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        chk("t5_awe", 32'(o_bus_awe), 32'd1);
        chk("t5_ams", 32'(o_bus_ams), 32'hF);
        chk("t5_doe", 32'(o_bus_doe), 32'd0);
        chk("t5_rdata", 32'(o_rsp_rdata), 32'd0);
        model_rdata = 16'h0000;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (15) @(negedge clk);
        chk("t5_cmd_ready", 32'(o_cmd_ready), 32'd1);
        @(posedge clk); #1;

        // T5b: normal read after reset
        send(1'b0, 2'd0, 19'h00010, 16'h0, 9, 1'b0, 1'b1);
        drain("t5b_drain");

`ifdef BF_ARDY_TIMEOUT_EN
        // T6: ARDY stuck low; abort after 8 WAIT clocks (edges 7..14),
        // HOLD edges 15..16, rsp_valid at 16; read data not updated.
        bus_ardy = 1'b0;
        repeat (3) @(posedge clk); #1;
        send(1'b0, 2'd0, 19'h00020, 16'h0, 16, 1'b1, 1'b1);
        drain("t6_drain");
        bus_ardy = 1'b1;
        repeat (3) @(posedge clk); #1;
`endif

        chk("final_queue_empty", 32'(sb_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
